// File: rtl/irq_gateway_rx4.sv
// rtl/irq_gateway_rx4.sv - receive-side gateway turning 4 async irq wires into claimed requests
//
// Optional feature macro: IRQ_GATEWAY_EDGE_EN (adds edge_mode[3:0] and per-source
// rising-edge detection with a one-deep deferred request).
//
// Ports:
//   clock           core clock, all flops rise-edge
//   reset           asynchronous active-high reset
//   irq_in[3:0]     raw asynchronous source wires
//   edge_mode[3:0]  (IRQ_GATEWAY_EDGE_EN only) per-source edge mode, static after reset
//   claim_valid     request offered to the core
//   claim_id[1:0]   source index of the offered request, stable while offered
//   claim_ready     core accepts the offer
//   complete_valid  one-cycle completion strobe
//   complete_id     source being completed
//   complete_err    one-cycle pulse: completion for a source not in flight
//   pending[3:0]    pending vector, debug readout

module irq_gateway_rx4 #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] irq_in,
`ifdef IRQ_GATEWAY_EDGE_EN
   input  logic [3:0] edge_mode,
`endif
   output logic       claim_valid,
   output logic [1:0] claim_id,
   input  logic       claim_ready,
   input  logic       complete_valid,
   input  logic [1:0] complete_id,
   output logic       complete_err,
   output logic [3:0] pending
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] sync_q [SYNC_STAGES];
   logic [3:0] sync_w;
   logic [3:0] pending_q, pending_d;
   logic [3:0] inflight_q, inflight_d;
   logic [1:0] claim_id_q, claim_id_d;
   logic       complete_err_q, complete_err_d;
   logic [1:0] low_id;
   logic       claim_fire;
   logic       cmp_hit;
   logic       cmp_miss;

`ifdef IRQ_GATEWAY_EDGE_EN
   logic [3:0] prev_q, prev_d;
   logic [3:0] deferred_q, deferred_d;
   logic [3:0] rise_w;
`endif

   // ---------------------------------------------------------------
   // Input synchronizers: bit-parallel shift chain, last stage is sync
   // ---------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q[0] <= irq_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign sync_w = sync_q[SYNC_STAGES-1];

`ifdef IRQ_GATEWAY_EDGE_EN
   assign rise_w = sync_w & ~prev_q;
   assign prev_d = sync_w;
`endif

   // ---------------------------------------------------------------
   // Handshake decode
   // ---------------------------------------------------------------
   assign claim_fire = (state_q == ST_OFFER) && claim_ready;
   assign cmp_hit    = complete_valid &&  inflight_q[complete_id];
   assign cmp_miss   = complete_valid && !inflight_q[complete_id];

   // Lowest-index pending source wins arbitration.
   always_comb begin
      low_id = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (pending_q[i]) begin
            low_id = 2'(i);
         end
      end
   end

   // ---------------------------------------------------------------
   // Pending / inflight / deferred next state
   // pending and inflight are mutually exclusive per source, so a set
   // and a clear never target the same bit in one cycle.
   // ---------------------------------------------------------------
   always_comb begin
      pending_d      = pending_q;
      inflight_d     = inflight_q;
      complete_err_d = cmp_miss;
`ifdef IRQ_GATEWAY_EDGE_EN
      deferred_d = deferred_q;
      // Level sources follow the synchronized level; edge sources only a rise.
      pending_d = pending_d
                | (sync_w & ~edge_mode & ~inflight_q & ~pending_q)
                | (rise_w &  edge_mode & ~inflight_q & ~pending_q);
`else
      pending_d = pending_d | (sync_w & ~inflight_q & ~pending_q);
`endif

      if (claim_fire) begin
         pending_d[claim_id_q]  = 1'b0;
         inflight_d[claim_id_q] = 1'b1;
      end

      if (cmp_hit) begin
         inflight_d[complete_id] = 1'b0;
`ifdef IRQ_GATEWAY_EDGE_EN
         if (deferred_q[complete_id]) begin
            pending_d[complete_id]  = 1'b1;
            deferred_d[complete_id] = 1'b0;
         end
`endif
      end

`ifdef IRQ_GATEWAY_EDGE_EN
      // A rise that cannot pend now is remembered once; extra rises are lost.
      deferred_d = deferred_d | (rise_w & edge_mode & (inflight_q | pending_q));
`endif
   end

   // ---------------------------------------------------------------
   // Offer FSM
   // ---------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      claim_id_d = claim_id_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|pending_q) begin
               claim_id_d = low_id;
               state_d    = ST_OFFER;
            end
         end
         ST_OFFER: begin
            // claim_id is frozen here even if a lower source becomes pending.
            if (claim_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         pending_q      <= '0;
         inflight_q     <= '0;
         claim_id_q     <= '0;
         complete_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pending_q      <= pending_d;
         inflight_q     <= inflight_d;
         claim_id_q     <= claim_id_d;
         complete_err_q <= complete_err_d;
      end
   end

`ifdef IRQ_GATEWAY_EDGE_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_q     <= '0;
         deferred_q <= '0;
      end else begin
         prev_q     <= prev_d;
         deferred_q <= deferred_d;
      end
   end
`endif

   assign claim_valid  = (state_q == ST_OFFER);
   assign claim_id     = claim_id_q;
   assign complete_err = complete_err_q;
   assign pending      = pending_q;

endmodule

// File: tb/tb_irq_gateway_rx4.sv
// tb/tb_irq_gateway_rx4.sv - directed self-checking bench for irq_gateway_rx4
module tb_irq_gateway_rx4;

   logic       clock;
   logic       reset;
   logic [3:0] irq_in;
   logic [3:0] edge_mode;
   logic       claim_valid;
   logic [1:0] claim_id;
   logic       claim_ready;
   logic       complete_valid;
   logic [1:0] complete_id;
   logic       complete_err;
   logic [3:0] pending;

   int n_checks;
   int n_errors;

   irq_gateway_rx4 #(.SYNC_STAGES(2)) dut (
      .clock          (clock),
      .reset          (reset),
      .irq_in         (irq_in),
`ifdef IRQ_GATEWAY_EDGE_EN
      .edge_mode      (edge_mode),
`endif
      .claim_valid    (claim_valid),
      .claim_id       (claim_id),
      .claim_ready    (claim_ready),
      .complete_valid (complete_valid),
      .complete_id    (complete_id),
      .complete_err   (complete_err),
      .pending        (pending)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check_eq("rst_valid", claim_valid, 0);
      check_eq("rst_pending", pending, 0);
      check_eq("rst_id", claim_id, 0);
      check_eq("rst_err", complete_err, 0);
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      irq_in         = 4'b0000;
      edge_mode      = 4'b0000;
      claim_ready    = 1'b0;
      complete_valid = 1'b0;
      complete_id    = 2'd0;
      n_checks       = 0;
      n_errors       = 0;

      // Reset state and quiet idle
      tick(2);
      do_reset();
      for (int c = 0; c < 20; c++) begin
         tick();
         check_eq("idle_valid", claim_valid, 0);
         check_eq("idle_pending", pending, 0);
         check_eq("idle_err", complete_err, 0);
      end

      // Single source latency: irq_in[2] at c0 -> offer at c4, pending clear at c5
      irq_in      = 4'b0100;
      claim_ready = 1'b1;
      tick(2);
      check_eq("lat_c2_pending", pending, 4'b0000);
      tick();
      check_eq("lat_c3_pending", pending, 4'b0100);
      check_eq("lat_c3_valid", claim_valid, 0);
      tick();
      check_eq("lat_c4_valid", claim_valid, 1);
      check_eq("lat_c4_id", claim_id, 2);
      tick();
      check_eq("lat_c5_pending", pending, 4'b0000);
      check_eq("lat_c5_valid", claim_valid, 0);
      irq_in = 4'b0000;
      tick(4);
      check_eq("lat_quiet_pending", pending, 4'b0000);

      // Completion of a source not in flight while id2 is in flight
      complete_valid = 1'b1;
      complete_id    = 2'd0;
      tick();
      complete_valid = 1'b0;
      check_eq("err_pulse", complete_err, 1);
      check_eq("err_pending", pending, 4'b0000);
      tick();
      check_eq("err_one_cycle", complete_err, 0);
      // id2 must still be in flight: completing it is not an error
      complete_valid = 1'b1;
      complete_id    = 2'd2;
      tick();
      complete_valid = 1'b0;
      check_eq("cmp2_noerr", complete_err, 0);
      tick(3);
      check_eq("cmp2_valid", claim_valid, 0);

      // Two sources held: 1010, ordered claims and re-offer after complete
      irq_in = 4'b1010;
      tick(3);
      check_eq("two_c3_pending", pending, 4'b1010);
      tick();
      check_eq("two_c4_valid", claim_valid, 1);
      check_eq("two_c4_id", claim_id, 1);
      tick();
      check_eq("two_c5_valid", claim_valid, 0);
      check_eq("two_c5_pending", pending, 4'b1000);
      tick();
      check_eq("two_c6_valid", claim_valid, 1);
      check_eq("two_c6_id", claim_id, 3);
      tick();
      check_eq("two_c7_pending", pending, 4'b0000);
      tick();
      check_eq("two_c8_valid", claim_valid, 0);
      check_eq("two_c8_pending", pending, 4'b0000);
      complete_valid = 1'b1;
      complete_id    = 2'd1;
      tick();
      check_eq("two_c9_err", complete_err, 0);
      check_eq("two_c9_pending", pending, 4'b0000);
      complete_id = 2'd3;
      tick();
      complete_valid = 1'b0;
      check_eq("two_c10_pending", pending, 4'b0010);
      check_eq("two_c10_err", complete_err, 0);
      tick();
      check_eq("two_c11_valid", claim_valid, 1);
      check_eq("two_c11_id", claim_id, 1);
      check_eq("two_c11_pending", pending, 4'b1010);
      tick();
      check_eq("two_c12_pending", pending, 4'b1000);
      tick();
      check_eq("two_c13_valid", claim_valid, 1);
      check_eq("two_c13_id", claim_id, 3);

      // Reset in the middle of an offer aborts it
      irq_in = 4'b0000;
      do_reset();
      tick(3);
      check_eq("post_rst_valid", claim_valid, 0);
      check_eq("post_rst_pending", pending, 0);

      // Held offer keeps its id while a lower source becomes pending
      claim_ready = 1'b0;
      irq_in      = 4'b1000;
      tick(4);
      check_eq("hold_c4_valid", claim_valid, 1);
      check_eq("hold_c4_id", claim_id, 3);
      irq_in = 4'b1001;
      tick(4);
      check_eq("hold_c8_valid", claim_valid, 1);
      check_eq("hold_c8_id", claim_id, 3);
      check_eq("hold_c8_pending", pending, 4'b1001);
      claim_ready = 1'b1;
      tick();
      check_eq("hold_c9_valid", claim_valid, 0);
      check_eq("hold_c9_pending", pending, 4'b0001);
      tick();
      check_eq("hold_c10_valid", claim_valid, 1);
      check_eq("hold_c10_id", claim_id, 0);
      tick();
      check_eq("hold_c11_pending", pending, 4'b0000);
      check_eq("hold_c11_valid", claim_valid, 0);

`ifdef IRQ_GATEWAY_EDGE_EN
      // Edge mode on source 1: one deferred request, extra pulse lost
      irq_in    = 4'b0000;
      edge_mode = 4'b0010;
      do_reset();
      tick(3);
      irq_in = 4'b0010;
      tick(3);
      irq_in = 4'b0000;
      check_eq("edge_c3_pending", pending, 4'b0010);
      tick();
      check_eq("edge_c4_valid", claim_valid, 1);
      check_eq("edge_c4_id", claim_id, 1);
      tick(2);
      irq_in = 4'b0010;
      tick(2);
      irq_in = 4'b0000;
      tick(2);
      irq_in = 4'b0010;
      tick(2);
      irq_in = 4'b0000;
      tick(4);
      check_eq("edge_c16_pending", pending, 4'b0000);
      check_eq("edge_c16_valid", claim_valid, 0);
      complete_valid = 1'b1;
      complete_id    = 2'd1;
      tick();
      complete_valid = 1'b0;
      check_eq("edge_c17_pending", pending, 4'b0010);
      check_eq("edge_c17_err", complete_err, 0);
      tick();
      check_eq("edge_c18_valid", claim_valid, 1);
      check_eq("edge_c18_id", claim_id, 1);
      tick();
      check_eq("edge_c19_pending", pending, 4'b0000);
      complete_valid = 1'b1;
      complete_id    = 2'd1;
      tick();
      complete_valid = 1'b0;
      check_eq("edge_c20_err", complete_err, 0);
      tick(4);
      check_eq("edge_dropped_pending", pending, 4'b0000);
      check_eq("edge_dropped_valid", claim_valid, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
